inv_sr_engine: RTL and testbench

- Sequential AES InvShiftRows stage for the decryption datapath; the inverse of the encrypt-side ShiftRows.
- Accepts one 128-bit state over a valid/ready handshake and un-rotates rows 1..3 (one row per cycle, or all at once when SERIAL=0).
- Presents the result on a held valid/ready output port.
- Sits between the inverse-round controller and the InvSubBytes stage.

---
 rtl/inv_sr_engine.sv | 131 +++++++++++++
 tb/tb_inv_sr_engine.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inv_sr_engine.sv
// AES InvShiftRows engine for the decryption datapath.
// A 128-bit state is accepted over a valid/ready handshake and rows 1..3 are
// rotated right by their row index, either one row per clock (SERIAL=1)
// or all at once on the load edge (SERIAL=0). The result is held on the
// output port until downstream takes it.
// Byte b of the state is row (b mod 4), column (b div 4), at bits [127-8b -: 8].

module inv_sr_engine #(
  parameter bit SERIAL = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  input  logic         in_bypass,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    ROW1 = 3'd1,
    ROW2 = 3'd2,
    ROW3 = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t       state_reg;
  logic [127:0] work_reg;
  logic         in_ready_reg;
  logic         out_valid_reg;
  logic         busy_reg;

  // Full inverse of the incoming block, used when all rows are done at once.
  logic [127:0] inv_all;
  // Working register with only row 1, 2 or 3 un-rotated, one per serial step.
  logic [127:0] row_rot [1:3];

  genvar gi, gr;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_inv
      localparam int R   = gi % 4;
      localparam int C   = gi / 4;
      localparam int SRC = R + 4 * ((C - R + 4) % 4);
      assign inv_all[127-8*gi -: 8] = in_data[127-8*SRC -: 8];
    end

    for (gr = 1; gr < 4; gr++) begin : g_row
      for (gi = 0; gi < 16; gi++) begin : g_byte
        localparam int R   = gi % 4;
        localparam int C   = gi / 4;
        localparam int SRC = R + 4 * ((C - R + 4) % 4);
        if (R == gr) begin : g_rot
          assign row_rot[gr][127-8*gi -: 8] = work_reg[127-8*SRC -: 8];
        end else begin : g_keep
          assign row_rot[gr][127-8*gi -: 8] = work_reg[127-8*gi -: 8];
        end
      end
    end
  endgenerate

  // Control FSM: load, per-row rotation steps, then hold the result until taken.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid && in_ready_reg) begin
            in_ready_reg <= 1'b0;
            busy_reg     <= 1'b1;
            if (in_bypass) begin
              // Bypass skips the rotation steps regardless of SERIAL.
              work_reg      <= in_data;
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end else if (SERIAL) begin
              work_reg  <= in_data;
              state_reg <= ROW1;
            end else begin
              work_reg      <= inv_all;
              state_reg     <= DONE;
              out_valid_reg <= 1'b1;
            end
          end
        end
        ROW1: begin
          work_reg  <= row_rot[1];
          state_reg <= ROW2;
        end
        ROW2: begin
          work_reg  <= row_rot[2];
          state_reg <= ROW3;
        end
        ROW3: begin
          work_reg      <= row_rot[3];
          state_reg     <= DONE;
          out_valid_reg <= 1'b1;
        end
        DONE: begin
          // Result stays frozen under backpressure; no accept overlaps unload.
          if (out_ready) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            in_ready_reg  <= 1'b1;
            busy_reg      <= 1'b0;
          end
        end
        default: begin
          state_reg     <= IDLE;
          in_ready_reg  <= 1'b1;
          out_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign out_valid = out_valid_reg;
  assign busy      = busy_reg;
  assign out_data  = work_reg;

endmodule

// File: tb/tb_inv_sr_engine.sv
// Testbench for inv_sr_engine: instance 0 is SERIAL=0, instance 1 is SERIAL=1.
module tb_inv_sr_engine;

  logic         clk = 1'b0;
  logic         rst       [2];
  logic         in_valid  [2];
  logic         in_ready  [2];
  logic [127:0] in_data   [2];
  logic         in_bypass [2];
  logic         out_valid [2];
  logic         out_ready [2];
  logic [127:0] out_data  [2];
  logic         busy      [2];

  int checks = 0;
  int passed = 0;

  logic [127:0] exp_q [$];

  always #5 clk = ~clk;

  inv_sr_engine #(.SERIAL(1'b0)) dut_par (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .in_data(in_data[0]), .in_bypass(in_bypass[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_data(out_data[0]), .busy(busy[0])
  );

  inv_sr_engine #(.SERIAL(1'b1)) dut_ser (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .in_data(in_data[1]), .in_bypass(in_bypass[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_data(out_data[1]), .busy(busy[1])
  );

  // Forward (encrypt-side) ShiftRows: out[r][c] = in[r][(c + r) mod 4].
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int b = 0; b < 16; b++) begin
      int r, c, src;
      r   = b % 4;
      c   = b / 4;
      src = r + 4 * ((c + r) % 4);
      o[127-8*b -: 8] = s[127-8*src -: 8];
    end
    return o;
  endfunction

  // Present a block and hold it until accepted; starts and ends just after a rising edge.
  task automatic send(input int u, input logic [127:0] d, input logic b, output bit ok);
    in_data[u]   = d;
    in_bypass[u] = b;
    in_valid[u]  = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (in_ready[u]) ok = 1'b1;
      @(posedge clk);
    end
    #1;
    in_valid[u] = 1'b0;
  endtask

  // Count falling edges after the accept edge until out_valid is seen (0 = timeout).
  task automatic measure(input int u, output int lat);
    lat = 0;
    for (int k = 1; k <= 20 && lat == 0; k++) begin
      @(negedge clk);
      if (out_valid[u]) lat = k;
    end
  endtask

  task automatic test_reset();
    rst[0] = 1'b1;
    rst[1] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    for (int u = 0; u < 2; u++) begin
      checks++;
      if (in_ready[u] !== 1'b1) $display("FAIL reset_in_ready u=%0d got=%b exp=1", u, in_ready[u]);
      else passed++;
      checks++;
      if (out_valid[u] !== 1'b0) $display("FAIL reset_out_valid u=%0d got=%b exp=0", u, out_valid[u]);
      else passed++;
      checks++;
      if (busy[u] !== 1'b0) $display("FAIL reset_busy u=%0d got=%b exp=0", u, busy[u]);
      else passed++;
      checks++;
      if (out_data[u] !== 128'h0) $display("FAIL reset_out_data u=%0d got=%h exp=0", u, out_data[u]);
      else passed++;
    end
  endtask

  // Single block with out_ready high; checks latency, data and one-cycle valid pulse.
  task automatic run_block(input string name, input int u, input logic [127:0] d, input logic b,
                           input logic [127:0] exp_d, input int exp_lat);
    bit ok;
    int lat;
    out_ready[u] = 1'b1;
    send(u, d, b, ok);
    checks++;
    if (!ok) $display("FAIL %s_accept got=no_accept exp=accept", name);
    else passed++;
    // A change of in_bypass after the accept edge must not affect this block.
    in_bypass[u] = ~b;
    measure(u, lat);
    checks++;
    if (lat !== exp_lat) $display("FAIL %s_latency got=%0d exp=%0d", name, lat, exp_lat);
    else passed++;
    checks++;
    if (out_data[u] !== exp_d) $display("FAIL %s_data got=%h exp=%h", name, out_data[u], exp_d);
    else passed++;
    @(negedge clk);
    checks++;
    if (out_valid[u] !== 1'b0) $display("FAIL %s_pulse got=%b exp=0", name, out_valid[u]);
    else passed++;
    in_bypass[u] = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_fips();
    run_block("fips_serial", 1, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b0,
              128'h7a9f102789d5f50b2beffd9f3dca4ea7, 4);
  endtask

  task automatic test_index();
    run_block("index_par", 0, 128'h000102030405060708090a0b0c0d0e0f, 1'b0,
              128'h000d0a0704010e0b0805020f0c090603, 1);
  endtask

  task automatic test_bypass();
    run_block("bypass_serial", 1, 128'h00112233445566778899aabbccddeeff, 1'b1,
              128'h00112233445566778899aabbccddeeff, 1);
    run_block("after_bypass_serial", 1, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b0,
              128'h7a9f102789d5f50b2beffd9f3dca4ea7, 4);
    run_block("bypass_par", 0, 128'h00112233445566778899aabbccddeeff, 1'b1,
              128'h00112233445566778899aabbccddeeff, 1);
  endtask

  task automatic test_backpressure();
    bit ok;
    int lat;
    logic [127:0] held;
    out_ready[1] = 1'b0;
    send(1, 128'h7ad5fda789ef4e272bca100b3d9ff59f, 1'b0, ok);
    measure(1, lat);
    checks++;
    if (lat !== 4) $display("FAIL bp_latency got=%0d exp=4", lat);
    else passed++;
    held = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    in_data[1]  = 128'hdeadbeefdeadbeefdeadbeefdeadbeef;
    in_valid[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid[1] !== 1'b1 || out_data[1] !== held || in_ready[1] !== 1'b0)
        $display("FAIL bp_hold cyc=%0d got=v%b r%b %h exp=v1 r0 %h",
                 i, out_valid[1], in_ready[1], out_data[1], held);
      else passed++;
    end
    in_valid[1]  = 1'b0;
    out_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0 || out_valid[1] !== 1'b0)
      $display("FAIL bp_release got=r%b b%b v%b exp=r1 b0 v0", in_ready[1], busy[1], out_valid[1]);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid[1] !== 1'b0) $display("FAIL bp_no_capture cyc=%0d got=%b exp=0", i, out_valid[1]);
      else passed++;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    bit ok;
    out_ready[1] = 1'b1;
    send(1, 128'h0123456789abcdef0123456789abcdef, 1'b0, ok);
    @(posedge clk);
    #1;
    rst[1] = 1'b1;
    @(posedge clk);
    #1;
    rst[1] = 1'b0;
    checks++;
    if (in_ready[1] !== 1'b1 || busy[1] !== 1'b0 || out_valid[1] !== 1'b0 || out_data[1] !== 128'h0)
      $display("FAIL mid_reset got=r%b b%b v%b %h exp=r1 b0 v0 0",
               in_ready[1], busy[1], out_valid[1], out_data[1]);
    else passed++;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid[1] !== 1'b0) $display("FAIL mid_reset_no_out cyc=%0d got=%b exp=0", i, out_valid[1]);
      else passed++;
    end
    @(posedge clk);
    #1;
  endtask

  // Random blocks: ShiftRows reference, then the engine; scoreboard checks order and count.
  task automatic test_round_trip(input int u, input int n);
    int received = 0;
    int budget;
    exp_q.delete();
    budget = n * 25 + 200;
    fork
      begin
        for (int i = 0; i < n; i++) begin
          logic [127:0] orig;
          bit byp;
          bit ok;
          orig = {$urandom, $urandom, $urandom, $urandom};
          byp  = ($urandom_range(0, 7) == 0);
          repeat ($urandom_range(0, 3)) @(posedge clk);
          #1;
          exp_q.push_back(orig);
          send(u, byp ? orig : shift_rows(orig), byp, ok);
          if (!ok) begin
            checks++;
            $display("FAIL rt_accept u=%0d blk=%0d got=no_accept exp=accept", u, i);
            break;
          end
        end
      end
      begin
        for (int cyc = 0; cyc < budget && received < n; cyc++) begin
          @(posedge clk);
          #1;
          out_ready[u] = ($urandom_range(0, 3) != 0);
          @(negedge clk);
          if (out_valid[u] && out_ready[u]) begin
            checks++;
            if (exp_q.size() == 0) begin
              $display("FAIL rt_extra u=%0d got=%h exp=none", u, out_data[u]);
            end else begin
              logic [127:0] e;
              e = exp_q.pop_front();
              if (out_data[u] !== e) $display("FAIL rt_data u=%0d n=%0d got=%h exp=%h", u, received, out_data[u], e);
              else passed++;
            end
            received++;
          end
        end
      end
    join
    out_ready[u] = 1'b1;
    checks++;
    if (received !== n || exp_q.size() != 0)
      $display("FAIL rt_count u=%0d got=%0d left=%0d exp=%0d left=0", u, received, exp_q.size(), n);
    else passed++;
    repeat (6) @(negedge clk);
    checks++;
    if (out_valid[u] !== 1'b0) $display("FAIL rt_trailing u=%0d got=%b exp=0", u, out_valid[u]);
    else passed++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int u = 0; u < 2; u++) begin
      rst[u]       = 1'b1;
      in_valid[u]  = 1'b0;
      in_data[u]   = '0;
      in_bypass[u] = 1'b0;
      out_ready[u] = 1'b0;
    end
    test_reset();
    test_fips();
    test_index();
    test_bypass();
    test_backpressure();
    test_reset_mid();
    test_round_trip(1, 1000);
    test_round_trip(0, 300);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
